// File: rtl/io_pad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_pad_pkg
// Purpose  : Shared types and constants for the GPIO pad bank.
//            io_mode_e encodes the per-channel drive mode; IO_SYNC_MIN is the
//            smallest synchroniser depth the channels will build.
// Config   : IO_PAD_FILTER_EN (optional input glitch filter, see io_pad_chan)
// Revision : 1.0 - initial release
// ============================================================================
package io_pad_pkg;

  typedef enum logic [1:0] {
    IO_PP   = 2'b00,  // push-pull
    IO_OD   = 2'b01,  // open-drain (drive low only)
    IO_IN   = 2'b10,  // input-only
    IO_RSVD = 2'b11   // reserved, treated as input-only
  } io_mode_e;

  localparam int IO_SYNC_MIN = 2;

endpackage
`default_nettype wire

// File: rtl/io_pad_chan.sv
`default_nettype none
// ============================================================================
// Module   : io_pad_chan
// Purpose  : One bidirectional GPIO channel: drive-mode decode, registered
//            pad output, OE turnaround guard, input synchroniser, optional
//            glitch filter, edge pulses and sticky interrupt bit.
// Ports    : clk, rst           clock, async active-high reset
//            out_i, oe_i        core data / drive request
//            mode_i[1:0]        io_mode_e drive mode
//            pad_in_i           pad cell C pin
//            pad_o_o, pad_oe_o  pad cell I pin / active-high output enable
//            core_in_o          synchronised (optionally filtered) input
//            rise_o, fall_o     1-cycle edge pulses on core_in_o
//            rise_en_i, fall_en_i, clear_i, pending_o  interrupt bit
// Config   : IO_PAD_FILTER_EN enables the FILT_CYCLES stability filter.
// Revision : 1.0 - initial release
// ============================================================================
module io_pad_chan
  import io_pad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TURN_CYCLES = 2
`ifdef IO_PAD_FILTER_EN
  , parameter int FILT_CYCLES = 4
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       out_i,
  input  logic       oe_i,
  input  logic [1:0] mode_i,
  input  logic       pad_in_i,
  output logic       pad_o_o,
  output logic       pad_oe_o,
  output logic       core_in_o,
  output logic       rise_o,
  output logic       fall_o,
  input  logic       rise_en_i,
  input  logic       fall_en_i,
  input  logic       clear_i,
  output logic       pending_o
);

  localparam int SYNC_N = (SYNC_STAGES < IO_SYNC_MIN) ? IO_SYNC_MIN : SYNC_STAGES;

  // --------------------------------------------------------------------------
  // Drive-mode decode
  // --------------------------------------------------------------------------
  logic req_oe_d;
  logic pad_o_d;

  always_comb begin
    req_oe_d = 1'b0;
    pad_o_d  = 1'b0;
    case (io_mode_e'(mode_i))
      IO_PP: begin
        req_oe_d = oe_i;
        pad_o_d  = out_i;
      end
      // Open-drain only ever drives a 0; a '1' is released to the pull-up.
      IO_OD:   req_oe_d = oe_i & ~out_i;
      default: ;
    endcase
  end

  logic pad_o_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pad_o_q <= 1'b0;
    else     pad_o_q <= pad_o_d;
  end

  // --------------------------------------------------------------------------
  // OE turnaround guard: enable only after req_oe has been stable long enough
  // for the far-end driver to release the line. Disable is immediate.
  // --------------------------------------------------------------------------
  logic pad_oe_q;

  if (TURN_CYCLES == 0) begin : g_no_turn
    always_ff @(posedge clk or posedge rst) begin
      if (rst) pad_oe_q <= 1'b0;
      else     pad_oe_q <= req_oe_d;
    end
  end else begin : g_turn
    localparam int            TW    = $clog2(TURN_CYCLES + 1);
    localparam logic [TW-1:0] TLAST = TW'(TURN_CYCLES);
    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q    <= '0;
        pad_oe_q <= 1'b0;
      end else if (!req_oe_d) begin
        cnt_q    <= '0;
        pad_oe_q <= 1'b0;
      end else begin
        if (cnt_q != TLAST) cnt_q <= cnt_q + 1'b1;
        pad_oe_q <= (cnt_q == TLAST);
      end
    end
  end

  assign pad_o_o  = pad_o_q;
  assign pad_oe_o = pad_oe_q;

  // --------------------------------------------------------------------------
  // Input synchroniser
  // --------------------------------------------------------------------------
  logic [SYNC_N-1:0] sync_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_N-2:0], pad_in_i};
  end

  logic sync_w;
  assign sync_w = sync_q[SYNC_N-1];

  logic din;

`ifdef IO_PAD_FILTER_EN
  // Accept a new level only after it has differed from the current one for
  // FILT_CYCLES consecutive samples; any return to the current level resets.
  localparam int            FILT_N = (FILT_CYCLES < 1) ? 1 : FILT_CYCLES;
  localparam int            FW     = $clog2(FILT_N + 1);
  localparam logic [FW-1:0] FLAST  = FW'(FILT_N - 1);

  logic [FW-1:0] filt_cnt_q;
  logic          filt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_cnt_q <= '0;
      filt_q     <= 1'b0;
    end else if (sync_w == filt_q) begin
      filt_cnt_q <= '0;
    end else if (filt_cnt_q == FLAST) begin
      filt_cnt_q <= '0;
      filt_q     <= sync_w;
    end else begin
      filt_cnt_q <= filt_cnt_q + 1'b1;
    end
  end

  assign din = filt_q;
`else
  assign din = sync_w;
`endif

  // --------------------------------------------------------------------------
  // Edge detect and sticky interrupt (set wins over clear)
  // --------------------------------------------------------------------------
  logic prev_q;
  logic pend_q;
  logic pend_d;

  assign rise_o = din & ~prev_q;
  assign fall_o = ~din & prev_q;
  assign pend_d = (rise_o & rise_en_i) | (fall_o & fall_en_i) | (pend_q & ~clear_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      prev_q <= din;
      pend_q <= pend_d;
    end
  end

  assign core_in_o = din;
  assign pending_o = pend_q;

endmodule
`default_nettype wire

// File: rtl/io_pad_bank.sv
`default_nettype none
// ============================================================================
// Module   : io_pad_bank
// Purpose  : Bank of NUM_IO independent bidirectional GPIO channels between
//            core logic and the chip-top pad cells (pad OEN = ~pad_oe).
// Ports    : clk, rst                       clock, async active-high reset
//            core_out/core_oe/core_mode      core drive controls
//            core_in, rise_pulse, fall_pulse synchronised input and edges
//            irq_rise_en/irq_fall_en/irq_clear, irq_pending, irq
//            pad_o, pad_oe, pad_i            pad cell I / ~OEN / C pins
// Config   : IO_PAD_FILTER_EN enables the per-channel input glitch filter.
// Revision : 1.0 - initial release
// ============================================================================
module io_pad_bank
  import io_pad_pkg::*;
#(
  parameter int NUM_IO      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TURN_CYCLES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IO-1:0]   core_out,
  input  logic [NUM_IO-1:0]   core_oe,
  input  logic [2*NUM_IO-1:0] core_mode,
  output logic [NUM_IO-1:0]   core_in,
  output logic [NUM_IO-1:0]   rise_pulse,
  output logic [NUM_IO-1:0]   fall_pulse,
  input  logic [NUM_IO-1:0]   irq_rise_en,
  input  logic [NUM_IO-1:0]   irq_fall_en,
  input  logic [NUM_IO-1:0]   irq_clear,
  output logic [NUM_IO-1:0]   irq_pending,
  output logic                irq,
  output logic [NUM_IO-1:0]   pad_o,
  output logic [NUM_IO-1:0]   pad_oe,
  input  logic [NUM_IO-1:0]   pad_i
);

  if (NUM_IO < 1 || NUM_IO > 32) begin : g_chk_num_io
    $error("io_pad_bank: NUM_IO must be in 1..32");
  end
  if (SYNC_STAGES < IO_SYNC_MIN) begin : g_chk_sync
    $error("io_pad_bank: SYNC_STAGES below minimum");
  end
  if (TURN_CYCLES < 0 || FILT_CYCLES < 1) begin : g_chk_cycles
    $error("io_pad_bank: invalid TURN_CYCLES or FILT_CYCLES");
  end

  for (genvar i = 0; i < NUM_IO; i++) begin : g_chan
    io_pad_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .TURN_CYCLES (TURN_CYCLES)
`ifdef IO_PAD_FILTER_EN
      , .FILT_CYCLES (FILT_CYCLES)
`endif
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .out_i     (core_out[i]),
      .oe_i      (core_oe[i]),
      .mode_i    (core_mode[2*i +: 2]),
      .pad_in_i  (pad_i[i]),
      .pad_o_o   (pad_o[i]),
      .pad_oe_o  (pad_oe[i]),
      .core_in_o (core_in[i]),
      .rise_o    (rise_pulse[i]),
      .fall_o    (fall_pulse[i]),
      .rise_en_i (irq_rise_en[i]),
      .fall_en_i (irq_fall_en[i]),
      .clear_i   (irq_clear[i]),
      .pending_o (irq_pending[i])
    );
  end

  assign irq = |irq_pending;

endmodule
`default_nettype wire

// File: tb/tb_io_pad_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_pad_bank
// Purpose  : Self-checking bench for io_pad_bank (NUM_IO=8, SYNC_STAGES=2,
//            TURN_CYCLES=2, FILT_CYCLES=4). Expected values are queued with
//            the cycle they are due; a monitor checks them on the falling edge.
// Config   : IO_PAD_FILTER_EN adds the glitch-filter directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_io_pad_bank;

  localparam int N = 8;
`ifdef IO_PAD_FILTER_EN
  localparam int LAT = 2 + 4;
`else
  localparam int LAT = 2;
`endif

  localparam int S_CIN  = 0;
  localparam int S_RISE = 1;
  localparam int S_FALL = 2;
  localparam int S_PEND = 3;
  localparam int S_IRQ  = 4;
  localparam int S_PADO = 5;
  localparam int S_OE   = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   core_out = '0;
  logic [N-1:0]   core_oe = '0;
  logic [2*N-1:0] core_mode = '0;
  logic [N-1:0]   core_in;
  logic [N-1:0]   rise_pulse;
  logic [N-1:0]   fall_pulse;
  logic [N-1:0]   irq_rise_en = '0;
  logic [N-1:0]   irq_fall_en = '0;
  logic [N-1:0]   irq_clear = '0;
  logic [N-1:0]   irq_pending;
  logic           irq;
  logic [N-1:0]   pad_o;
  logic [N-1:0]   pad_oe;
  logic [N-1:0]   pad_i = '0;

  io_pad_bank #(
    .NUM_IO      (N),
    .SYNC_STAGES (2),
    .TURN_CYCLES (2),
    .FILT_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .core_out    (core_out),
    .core_oe     (core_oe),
    .core_mode   (core_mode),
    .core_in     (core_in),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .irq_rise_en (irq_rise_en),
    .irq_fall_en (irq_fall_en),
    .irq_clear   (irq_clear),
    .irq_pending (irq_pending),
    .irq         (irq),
    .pad_o       (pad_o),
    .pad_oe      (pad_oe),
    .pad_i       (pad_i)
  );

  always #5 clk = ~clk;

  int cyc    = 0;
  int n_vec  = 0;
  int n_err  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           due;
    int           sig;
    logic [N-1:0] mask;
    logic [N-1:0] val;
    string        name;
  } exp_t;

  exp_t sb[$];

  function automatic logic [N-1:0] get_sig(int s);
    case (s)
      S_CIN:   return core_in;
      S_RISE:  return rise_pulse;
      S_FALL:  return fall_pulse;
      S_PEND:  return irq_pending;
      S_IRQ:   return {{(N-1){1'b0}}, irq};
      S_PADO:  return pad_o;
      default: return pad_oe;
    endcase
  endfunction

  // Monitor: compare every expectation that is due this cycle.
  always @(negedge clk) begin
    logic [N-1:0] act;
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].due <= cyc) begin
        act = get_sig(sb[k].sig) & sb[k].mask;
        n_vec++;
        if (sb[k].due < cyc || act !== (sb[k].val & sb[k].mask)) begin
          n_err++;
          $display("FAIL %s: got %h expected %h (mask %h) at cycle %0d",
                   sb[k].name, act, sb[k].val & sb[k].mask, sb[k].mask, cyc);
        end
        sb.delete(k);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_at(input int dly, input int sig, input logic [N-1:0] mask,
                        input logic [N-1:0] val, input string nm);
    exp_t e;
    e.due  = cyc + dly;
    e.sig  = sig;
    e.mask = mask;
    e.val  = val;
    e.name = nm;
    sb.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    rst = 1'b0;
    step(3);

    // Reset state
    exp_at(0, S_CIN,  8'hFF, 8'h00, "rst_core_in");
    exp_at(0, S_OE,   8'hFF, 8'h00, "rst_pad_oe");
    exp_at(0, S_PADO, 8'hFF, 8'h00, "rst_pad_o");
    exp_at(0, S_PEND, 8'hFF, 8'h00, "rst_pending");
    exp_at(0, S_IRQ,  8'h01, 8'h00, "rst_irq");

    n_vec++;
    if (core_in !== 8'h00) begin
      n_err++;
      $display("FAIL direct_rst_core_in: got %h expected %h", core_in, 8'h00);
    end
    n_vec++;
    if (pad_oe !== 8'h00) begin
      n_err++;
      $display("FAIL direct_rst_pad_oe: got %h expected %h", pad_oe, 8'h00);
    end
    n_vec++;
    if (pad_o !== 8'h00) begin
      n_err++;
      $display("FAIL direct_rst_pad_o: got %h expected %h", pad_o, 8'h00);
    end
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL direct_rst_irq: got %b expected %b", irq, 1'b0);
    end

    // Mid-run asynchronous reset
    pad_i = 8'hFF; core_out = 8'hFF; core_oe = 8'hFF; core_mode = '0;
    step(LAT + 4);
    exp_at(0, S_CIN,  8'hFF, 8'hFF, "pre_rst_core_in");
    exp_at(0, S_OE,   8'hFF, 8'hFF, "pre_rst_pad_oe");
    exp_at(0, S_PADO, 8'hFF, 8'hFF, "pre_rst_pad_o");
    step(1);
    rst = 1'b1;
    exp_at(0, S_CIN,  8'hFF, 8'h00, "async_rst_core_in");
    exp_at(0, S_OE,   8'hFF, 8'h00, "async_rst_pad_oe");
    exp_at(0, S_PADO, 8'hFF, 8'h00, "async_rst_pad_o");
    exp_at(0, S_RISE, 8'hFF, 8'h00, "async_rst_rise");
    exp_at(0, S_FALL, 8'hFF, 8'h00, "async_rst_fall");
    #1;
    n_vec++;
    if (pad_oe !== 8'h00) begin
      n_err++;
      $display("FAIL direct_async_rst_pad_oe: got %h expected %h", pad_oe, 8'h00);
    end
    n_vec++;
    if (core_in !== 8'h00) begin
      n_err++;
      $display("FAIL direct_async_rst_core_in: got %h expected %h", core_in, 8'h00);
    end
    n_vec++;
    if (pad_o !== 8'h00) begin
      n_err++;
      $display("FAIL direct_async_rst_pad_o: got %h expected %h", pad_o, 8'h00);
    end
    step(1);
    rst = 1'b0;
    exp_at(LAT - 1, S_CIN,  8'hFF, 8'h00, "post_rst_core_in_early");
    exp_at(LAT,     S_CIN,  8'hFF, 8'hFF, "post_rst_core_in");
    exp_at(LAT,     S_RISE, 8'hFF, 8'hFF, "post_rst_rise");
    exp_at(LAT + 1, S_RISE, 8'hFF, 8'h00, "post_rst_rise_end");
    exp_at(1,       S_PADO, 8'hFF, 8'hFF, "post_rst_pad_o");
    exp_at(2,       S_OE,   8'hFF, 8'h00, "post_rst_oe_guard");
    exp_at(3,       S_OE,   8'hFF, 8'hFF, "post_rst_oe_on");
    exp_at(LAT + 1, S_PEND, 8'hFF, 8'h00, "post_rst_no_pending");
    step(LAT + 3);

    // Push-pull
    core_oe = 8'h00;
    exp_at(1, S_OE, 8'hFF, 8'h00, "pp_oe_drop");
    step(3);
    core_out = 8'h0F; core_oe = 8'h0F;
    exp_at(0, S_PADO, 8'hFF, 8'hFF, "pp_pad_o_old");
    exp_at(1, S_PADO, 8'hFF, 8'h0F, "pp_pad_o_new");
    exp_at(2, S_OE,   8'hFF, 8'h00, "pp_oe_guard");
    exp_at(3, S_OE,   8'hFF, 8'h0F, "pp_oe_on");
    step(1);
    n_vec++;
    if (pad_o !== 8'h0F) begin
      n_err++;
      $display("FAIL direct_pp_pad_o: got %h expected %h", pad_o, 8'h0F);
    end
    step(3);
    core_oe = 8'h00;
    exp_at(0, S_OE, 8'hFF, 8'h0F, "pp_oe_held");
    exp_at(1, S_OE, 8'hFF, 8'h00, "pp_oe_off");
    step(3);

    // Open-drain on channel 0
    core_mode = 16'h0001; core_out = 8'hFF; core_oe = 8'h01;
    exp_at(1, S_PADO, 8'h01, 8'h00, "od_pad_o_zero");
    exp_at(4, S_OE,   8'h01, 8'h00, "od_release_high");
    step(5);
    n_vec++;
    if (pad_oe[0] !== 1'b0) begin
      n_err++;
      $display("FAIL direct_od_release: got %b expected %b", pad_oe[0], 1'b0);
    end
    core_out = 8'hFE;
    exp_at(2, S_OE,   8'h01, 8'h00, "od_guard");
    exp_at(3, S_OE,   8'h01, 8'h01, "od_drive_low");
    exp_at(3, S_PADO, 8'h01, 8'h00, "od_pad_o_low");
    step(4);
    core_out = 8'hFF;
    exp_at(1, S_OE, 8'h01, 8'h00, "od_release");
    step(2);
    core_out = 8'hFE;
    exp_at(2, S_OE, 8'h01, 8'h00, "od_guard2");
    exp_at(3, S_OE, 8'h01, 8'h01, "od_drive_low2");
    step(4);
    core_mode = 16'h0003;
    exp_at(1, S_OE,   8'h01, 8'h00, "rsvd_oe_off");
    exp_at(4, S_OE,   8'h01, 8'h00, "rsvd_oe_stays_off");
    exp_at(4, S_PADO, 8'h01, 8'h00, "rsvd_pad_o");
    step(5);
    core_mode = '0; core_oe = 8'h00; core_out = 8'h00;
    step(3);

    // Turnaround abort on channel 2
    core_oe = 8'h04;
    step(1);
    core_oe = 8'h00;
    step(1);
    core_oe = 8'h04;
    exp_at(2, S_OE, 8'h04, 8'h00, "abort_restart");
    exp_at(3, S_OE, 8'h04, 8'h04, "abort_oe_on");
    step(5);
    core_oe = 8'h00;
    step(2);

    // Edges and interrupts on channel 3
    irq_rise_en = 8'h08;
    pad_i = 8'h00;
    exp_at(LAT,     S_FALL, 8'hFF, 8'hFF, "fall_all");
    exp_at(LAT + 1, S_FALL, 8'hFF, 8'h00, "fall_all_end");
    exp_at(LAT + 2, S_PEND, 8'hFF, 8'h00, "fall_no_irq");
    step(LAT + 4);
    pad_i = 8'h08;
    exp_at(LAT - 1, S_RISE, 8'hFF, 8'h00, "rise_early");
    exp_at(LAT,     S_RISE, 8'hFF, 8'h08, "rise_ch3");
    exp_at(LAT + 1, S_RISE, 8'hFF, 8'h00, "rise_ch3_end");
    exp_at(LAT,     S_PEND, 8'hFF, 8'h00, "pend_not_yet");
    exp_at(LAT + 1, S_PEND, 8'hFF, 8'h08, "pend_set");
    exp_at(LAT + 1, S_IRQ,  8'h01, 8'h01, "irq_set");
    exp_at(LAT + 5, S_PEND, 8'hFF, 8'h08, "pend_sticky");
    step(LAT + 6);
    irq_clear = 8'h08;
    exp_at(0, S_PEND, 8'hFF, 8'h08, "pend_before_clear");
    exp_at(1, S_PEND, 8'hFF, 8'h00, "pend_cleared");
    exp_at(1, S_IRQ,  8'h01, 8'h00, "irq_cleared");
    step(1);
    irq_clear = 8'h00;
    pad_i = 8'h00;
    step(LAT + 3);
    pad_i = 8'h08;
    step(LAT);
    irq_clear = 8'h08;
    exp_at(0, S_RISE, 8'hFF, 8'h08, "rise_with_clear");
    exp_at(1, S_PEND, 8'hFF, 8'h08, "set_beats_clear");
    exp_at(1, S_IRQ,  8'h01, 8'h01, "irq_set_beats_clear");
    n_vec++;
    if (rise_pulse[3] !== 1'b1) begin
      n_err++;
      $display("FAIL direct_rise_with_clear: got %b expected %b", rise_pulse[3], 1'b1);
    end
    step(1);
    irq_clear = 8'h00;
    step(3);
    irq_clear = 8'h08;
    step(1);
    irq_clear = 8'h00;
    irq_rise_en = 8'h00;
    irq_fall_en = 8'h08;
    pad_i = 8'h00;
    exp_at(0,       S_PEND, 8'hFF, 8'h00, "pend_cleared2");
    exp_at(LAT,     S_FALL, 8'hFF, 8'h08, "fall_ch3");
    exp_at(LAT + 1, S_PEND, 8'hFF, 8'h08, "pend_fall");
    step(LAT + 3);

`ifdef IO_PAD_FILTER_EN
    // Glitch filter on channel 1
    pad_i = 8'h02;
    exp_at(5, S_RISE, 8'h02, 8'h00, "glitch_no_rise5");
    exp_at(6, S_CIN,  8'h02, 8'h00, "glitch_core_in6");
    exp_at(6, S_RISE, 8'h02, 8'h00, "glitch_no_rise6");
    exp_at(7, S_CIN,  8'h02, 8'h00, "glitch_core_in7");
    step(3);
    pad_i = 8'h00;
    step(8);
    pad_i = 8'h02;
    exp_at(5, S_CIN,  8'h02, 8'h00, "filt_core_in_early");
    exp_at(6, S_CIN,  8'h02, 8'h02, "filt_core_in");
    exp_at(6, S_RISE, 8'h02, 8'h02, "filt_rise");
    step(4);
    pad_i = 8'h00;
    step(10);
`endif

    step(4);
    while (sb.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got unchecked expected check at cycle %0d", sb[0].name, sb[0].due);
      void'(sb.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
